// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
//
// Purpose:
//   Byte-oriented serial transmitter sitting between the core's UART byte
//   port and the TxD pad. Bytes pushed by the core are held in a small FIFO
//   and sent as 8N1 frames: one start bit (0), eight data bits LSB first,
//   one stop bit (1). Every bit lasts exactly CLKS_PER_BIT clock cycles.
//   Consecutive queued bytes go out back-to-back: the next start bit
//   follows the previous stop bit with no idle gap.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   FIFO_LOG2     log2 of the FIFO depth
//
// Ports:
//   clk           system clock, all state changes on the rising edge
//   rst           asynchronous active-high reset
//   TxD_start     push strobe, sampled on every rising edge
//   TxD_data      byte to push, only looked at while TxD_start=1
//   TxD_full      FIFO holds DEPTH entries (registered)
//   TxD_busy      FIFO non-empty or a frame in flight (registered)
//   TxD_overflow  sticky flag: a push arrived while full and was dropped
//   TxD           serial line, registered, idles high
//
// State table:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line high, waiting for the FIFO to hold a byte
//   ST_START | driving the start bit (0)
//   ST_DATA  | driving data bit bi_q from shift_q[0]
//   ST_STOP  | driving the stop bit (1); may chain straight into ST_START
// ----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_LOG2    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD_full,
    output logic       TxD_busy,
    output logic       TxD_overflow,
    output logic       TxD
);

    localparam int DEPTH = 2 ** FIFO_LOG2;
    localparam int BCW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BCW-1:0]     BC_LAST  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_LOG2:0] CNT_FULL = (FIFO_LOG2 + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]           state_q,  state_d;
    logic [BCW-1:0]       bc_q,     bc_d;
    logic [2:0]           bi_q,     bi_d;
    logic [7:0]           shift_q,  shift_d;
    logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2:0]   count_q,  count_d;
    logic                 full_q,   full_d;
    logic                 busy_q,   busy_d;
    logic                 ovf_q,    ovf_d;
    logic                 txd_q,    txd_d;

    logic [7:0]           mem_q [DEPTH];

    logic                 bc_last;
    logic                 fifo_nonempty;
    logic                 pop;
    logic                 push;
    logic                 drop;

    assign bc_last       = (bc_q == BC_LAST);
    assign fifo_nonempty = (count_q != '0);

    // Push acceptance uses the pre-edge full flag. A pop on the same edge
    // does not rescue a push that arrives while full.
    assign push = TxD_start & ~full_q;
    assign drop = TxD_start &  full_q;

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        bc_d    = bc_q;
        bi_d    = bi_q;
        shift_d = shift_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // count_q is the pre-edge value, so a byte pushed into an
                // empty FIFO is only seen here one edge later.
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    bc_d    = '0;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (bc_last) begin
                    bc_d    = '0;
                    bi_d    = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    bc_d = bc_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (bc_last) begin
                    bc_d    = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bi_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bi_d = bi_q + 3'd1;
                    end
                end else begin
                    bc_d = bc_q + 1'b1;
                end
            end

            ST_STOP: begin
                if (bc_last) begin
                    bc_d = '0;
                    // Chain directly into the next start bit when another
                    // byte is waiting, keeping frames gap-free.
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bc_d = bc_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                bc_d    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, derived from next-state so they line up with
    // the state they describe (start bit appears right after the pop edge).
    // ------------------------------------------------------------------
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase

        busy_d = (count_d != '0) | (state_d != ST_IDLE);
        full_d = (count_d == CNT_FULL);
        ovf_d  = ovf_q | drop;
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            bc_q     <= '0;
            bi_q     <= 3'd0;
            shift_q  <= 8'h00;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            bc_q     <= bc_d;
            bi_q     <= bi_d;
            shift_q  <= shift_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            txd_q    <= txd_d;
        end
    end

    // Storage array needs no reset: count/pointers define which entries
    // are valid, and reset empties the FIFO through those.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= TxD_data;
        end
    end

    assign TxD          = txd_q;
    assign TxD_full     = full_q;
    assign TxD_busy     = busy_q;
    assign TxD_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int LOG2  = 2;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       TxD_start = 1'b0;
    logic [7:0] TxD_data  = 8'h00;
    logic       TxD_full;
    logic       TxD_busy;
    logic       TxD_overflow;
    logic       TxD;

    int total = 0;
    int bad   = 0;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_LOG2    (LOG2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .TxD_start    (TxD_start),
        .TxD_data     (TxD_data),
        .TxD_full     (TxD_full),
        .TxD_busy     (TxD_busy),
        .TxD_overflow (TxD_overflow),
        .TxD          (TxD)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: a byte queue plus "which cycle of the current
    // frame are we in". The line value is read off the frame position.
    // ------------------------------------------------------------------
    logic [7:0] m_q[$];
    bit         m_active = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_byte   = 8'h00;
    bit         m_ovf    = 1'b0;
    int         m_frames = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                m_active = 1'b0;
                m_pos    = 0;
                m_ovf    = 1'b0;
            end else begin
                int  pre_size;
                bit  start_frame;
                pre_size    = m_q.size();
                start_frame = 1'b0;
                if (m_active) begin
                    if (m_pos == FRAME - 1) begin
                        if (pre_size > 0) start_frame = 1'b1;
                        else              m_active    = 1'b0;
                    end else begin
                        m_pos++;
                    end
                end else if (pre_size > 0) begin
                    start_frame = 1'b1;
                end
                if (start_frame) begin
                    m_byte   = m_q.pop_front();
                    m_active = 1'b1;
                    m_pos    = 0;
                    m_frames++;
                end
                if (TxD_start) begin
                    if (pre_size == DEPTH) m_ovf = 1'b1;
                    else                   m_q.push_back(TxD_data);
                end
            end
        end
    end

    function automatic logic exp_txd();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_pos / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_byte[idx-1];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("m_txd",  {31'd0, TxD},          {31'd0, exp_txd()});
            check("m_busy", {31'd0, TxD_busy},     {31'd0, (m_active || m_q.size() > 0)});
            check("m_full", {31'd0, TxD_full},     {31'd0, (m_q.size() == DEPTH)});
            check("m_ovf",  {31'd0, TxD_overflow}, {31'd0, m_ovf});
        end
    end

    logic [7:0] vec [8];

    // Holds TxD_start high for n consecutive rising edges with vec[0..n-1].
    // Returns at the negedge just after the last push edge.
    task automatic push_n(input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            TxD_data  = vec[i];
            TxD_start = 1'b1;
            @(negedge clk);
        end
        TxD_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (TxD_busy !== 1'b0 && n < budget);
        check(name, {31'd0, TxD_busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        int         f0;
        int         cnt;
        int         n;
        bit         full_seen;

        // Reset values.
        #12;
        check("rst_txd",  {31'd0, TxD},          32'd1);
        check("rst_busy", {31'd0, TxD_busy},     32'd0);
        check("rst_full", {31'd0, TxD_full},     32'd0);
        check("rst_ovf",  {31'd0, TxD_overflow}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        // 1. Single 0xA5 frame: 0,1,0,1,0,0,1,0,1,1 (index 0 first).
        pat    = 10'b1101001010;
        vec[0] = 8'hA5;
        f0     = m_frames;
        push_n(1);
        check("t1_busy_push", {31'd0, TxD_busy}, 32'd1);
        check("t1_txd_push",  {31'd0, TxD},      32'd1);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            check("t1_bit", {31'd0, TxD}, {31'd0, pat[i / CPB]});
        end
        @(negedge clk);
        check("t1_busy_end", {31'd0, TxD_busy}, 32'd0);
        check("t1_frames",   m_frames - f0,     32'd1);

        // 2. Three back-to-back frames. Pop at edge N+1, end at N+1+3*FRAME;
        //    counting starts from the sample after N+2.
        vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'h55;
        f0 = m_frames;
        push_n(3);
        full_seen = TxD_full;
        cnt = 0;
        while (TxD_busy === 1'b1 && cnt < 500) begin
            @(negedge clk);
            cnt++;
            if (TxD_full) full_seen = 1'b1;
        end
        check("t2_cycles", cnt,                    3 * FRAME - 1);
        check("t2_full",   {31'd0, full_seen},     32'd0);
        check("t2_frames", m_frames - f0,          32'd3);

        // 3. Six pushes on consecutive edges: one popped, four fill, one dropped.
        do_reset();
        check("t3_ovf_pre", {31'd0, TxD_overflow}, 32'd0);
        vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33;
        vec[3] = 8'h44; vec[4] = 8'h55; vec[5] = 8'h66;
        f0 = m_frames;
        push_n(6);
        check("t3_full", {31'd0, TxD_full},     32'd1);
        check("t3_ovf",  {31'd0, TxD_overflow}, 32'd1);
        wait_idle("t3_idle", 5 * FRAME + 20);
        check("t3_frames", m_frames - f0, 32'd5);
        check("t3_ovf_sticky", {31'd0, TxD_overflow}, 32'd1);

        // 4. Reset during data bit 3 with two bytes queued. 0x37 has bit3=0,
        //    so the line is low just before reset.
        do_reset();
        vec[0] = 8'h37; vec[1] = 8'hC3; vec[2] = 8'h5A;
        push_n(3);
        repeat (16) @(negedge clk);
        check("t4_pre_txd", {31'd0, TxD}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_txd",  {31'd0, TxD},          32'd1);
        check("t4_rst_busy", {31'd0, TxD_busy},     32'd0);
        check("t4_rst_full", {31'd0, TxD_full},     32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        f0 = m_frames;
        repeat (2 * FRAME) @(negedge clk);
        check("t4_quiet_txd",  {31'd0, TxD},      32'd1);
        check("t4_quiet_busy", {31'd0, TxD_busy}, 32'd0);
        check("t4_no_frames",  m_frames - f0,     32'd0);
        vec[0] = 8'h3C;
        push_n(1);
        wait_idle("t4_idle", FRAME + 20);
        check("t4_frames", m_frames - f0, 32'd1);

        // 5. FIFO full, push on the edge the stop bit ends and the next byte pops.
        do_reset();
        vec[0] = 8'h01; vec[1] = 8'h02; vec[2] = 8'h03; vec[3] = 8'h04; vec[4] = 8'h05;
        f0 = m_frames;
        push_n(5);
        check("t5_full_pre", {31'd0, TxD_full}, 32'd1);
        n = 0;
        while (!(m_active && m_pos == FRAME - 1) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("t5_sync", {31'd0, (m_pos == FRAME - 1)}, 32'd1);
        TxD_data  = 8'hEE;
        TxD_start = 1'b1;
        @(negedge clk);
        TxD_start = 1'b0;
        check("t5_full_post", {31'd0, TxD_full},     32'd0);
        check("t5_ovf",       {31'd0, TxD_overflow}, 32'd1);
        check("t5_txd_start", {31'd0, TxD},          32'd0);
        wait_idle("t5_idle", 5 * FRAME + 20);
        check("t5_frames", m_frames - f0, 32'd5);

        // 6. TxD_data toggling with TxD_start low has no effect.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            TxD_data = 8'(i * 37);
            check("t6_txd",  {31'd0, TxD},      32'd1);
            check("t6_busy", {31'd0, TxD_busy}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
